// File: rtl/ula_sequencer_if.sv
// Signal bundle between the command source, ula_sequencer, the ula and the result sink.
interface ula_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OP_W-1:0]   in_op;

    logic [DATA_W-1:0] ula_a;
    logic [DATA_W-1:0] ula_b;
    logic [OP_W-1:0]   ula_op;
    logic [DATA_W-1:0] ula_s;
    logic              ula_flag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_s;
    logic              out_flag;
    logic              out_err;
    logic [OP_W-1:0]   out_op;
    logic [7:0]        op_count;

    modport slave (
        input  in_valid, in_a, in_b, in_op, ula_s, ula_flag, out_ready,
        output in_ready, ula_a, ula_b, ula_op,
        output out_valid, out_s, out_flag, out_err, out_op, op_count
    );

    modport master (
        output in_valid, in_a, in_b, in_op, ula_s, ula_flag, out_ready,
        input  in_ready, ula_a, ula_b, ula_op,
        input  out_valid, out_s, out_flag, out_err, out_op, op_count
    );
endinterface

// File: rtl/ula_sequencer.sv
// Command sequencer for the ula: holds operands for the ula pipeline latency,
// captures the result and hands it downstream, flagging unimplemented opcodes.
module ula_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned N_OPS   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ula_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] ula_a_nxt;
    logic [DATA_W-1:0] ula_b_nxt;
    logic [OP_W-1:0]   ula_op_nxt;
    logic [DATA_W-1:0] out_s_nxt;
    logic              out_flag_nxt;
    logic              out_err_nxt;
    logic [OP_W-1:0]   out_op_nxt;
    logic [7:0]        op_count_nxt;

    logic accept;
    logic op_legal;
    logic capture;
    logic xfer;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign op_legal = (32'(bus.in_op) < N_OPS);
    assign capture  = (state == WAIT) && (cnt == CNT_W'(LATENCY));
    assign xfer     = (state == DONE) && bus.out_ready;

    // State and registered outputs; handshake flags are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.ula_a     <= '0;
            bus.ula_b     <= '0;
            bus.ula_op    <= '0;
            bus.out_s     <= '0;
            bus.out_flag  <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.out_op    <= '0;
            bus.op_count  <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            bus.in_ready  <= (state_nxt == IDLE);
            bus.out_valid <= (state_nxt == DONE);
            bus.ula_a     <= ula_a_nxt;
            bus.ula_b     <= ula_b_nxt;
            bus.ula_op    <= ula_op_nxt;
            bus.out_s     <= out_s_nxt;
            bus.out_flag  <= out_flag_nxt;
            bus.out_err   <= out_err_nxt;
            bus.out_op    <= out_op_nxt;
            bus.op_count  <= op_count_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = op_legal ? WAIT : DONE;
            WAIT:    if (capture) state_nxt = DONE;
            DONE:    if (xfer)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath register updates; everything holds unless the current state acts on it.
    always_comb begin
        cnt_nxt      = cnt;
        ula_a_nxt    = bus.ula_a;
        ula_b_nxt    = bus.ula_b;
        ula_op_nxt   = bus.ula_op;
        out_s_nxt    = bus.out_s;
        out_flag_nxt = bus.out_flag;
        out_err_nxt  = bus.out_err;
        out_op_nxt   = bus.out_op;
        op_count_nxt = bus.op_count;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op_legal) begin
                        ula_a_nxt  = bus.in_a;
                        ula_b_nxt  = bus.in_b;
                        ula_op_nxt = bus.in_op;
                        cnt_nxt    = '0;
                    end else begin
                        out_s_nxt    = '0;
                        out_flag_nxt = 1'b0;
                        out_err_nxt  = 1'b1;
                        out_op_nxt   = bus.in_op;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                // Operands are still held here, so s and flag belong to the same op.
                if (capture) begin
                    out_s_nxt    = bus.ula_s;
                    out_flag_nxt = bus.ula_flag;
                    out_err_nxt  = 1'b0;
                    out_op_nxt   = bus.ula_op;
                end
            end
            DONE: begin
                if (xfer) op_count_nxt = bus.op_count + 8'd1;
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_ula_sequencer.sv
// Randomized self-checking bench for ula_sequencer with a two-stage ula stub
// and an arithmetic reference model.
module tb_ula_sequencer;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned N_OPS   = 2;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   exp_count = 0;

    ula_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    ula_sequencer #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .LATENCY(LATENCY),
        .N_OPS  (N_OPS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ula stub: input register then output register; flag is carry (add) or borrow (sub)
    logic [7:0] ua_r = 8'd0;
    logic [7:0] ub_r = 8'd0;
    logic [2:0] uop_r = 3'd0;
    logic [7:0] us_r = 8'd0;
    logic       uf_r = 1'b0;
    assign bus.ula_s    = us_r;
    assign bus.ula_flag = uf_r;

    always @(posedge clk) begin
        ua_r  <= bus.ula_a;
        ub_r  <= bus.ula_b;
        uop_r <= bus.ula_op;
        if (uop_r == 3'd1) {uf_r, us_r} <= {1'b0, ua_r} - {1'b0, ub_r};
        else               {uf_r, us_r} <= {1'b0, ua_r} + {1'b0, ub_r};
    end

    function automatic void ref_model(input int a, input int b, input int op,
                                      output int s, output int f, output int e);
        if (op >= int'(N_OPS)) begin
            s = 0; f = 0; e = 1;
        end else if (op == 0) begin
            s = (a + b) % 256; f = (a + b > 255) ? 1 : 0; e = 0;
        end else begin
            s = (a - b + 256) % 256; f = (a < b) ? 1 : 0; e = 0;
        end
    endfunction

    function automatic int rand_op();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 1));
    endfunction

    task automatic issue_and_check(input int a, input int b, input int op, input int stall,
                                   input string tag);
        int s, f, e, n, exp_n;
        logic [7:0] pa, pb, hs;
        logic [2:0] pop, ho;
        logic       hf, he;
        ref_model(a, b, op, s, f, e);
        exp_n = (e != 0) ? 1 : int'(LATENCY) + 2;
        pa = bus.ula_a; pb = bus.ula_b; pop = bus.ula_op;
        if (e == 0) begin
            pa = 8'(a); pb = 8'(b); pop = 3'(op);
        end
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 8'(a); bus.in_b = 8'(b); bus.in_op = 3'(op);
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL %s in_ready_after_accept: got %b want 0", tag, bus.in_ready);
        end
        total++;
        if ({bus.ula_a, bus.ula_b, bus.ula_op} !== {pa, pb, pop}) begin
            bad++; $display("FAIL %s ula_load: got %h/%h/%0d want %h/%h/%0d", tag,
                            bus.ula_a, bus.ula_b, bus.ula_op, pa, pb, pop);
        end
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            bus.in_valid = 1'($urandom);
            bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_op = 3'($urandom);
            @(negedge clk);
            n++;
        end
        total++;
        if (n != exp_n) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", tag, n, exp_n);
        end
        total++;
        if (bus.out_s !== 8'(s) || bus.out_flag !== 1'(f) || bus.out_err !== 1'(e) || bus.out_op !== 3'(op)) begin
            bad++; $display("FAIL %s result: got s=%h f=%b e=%b op=%0d want s=%h f=%0d e=%0d op=%0d", tag,
                            bus.out_s, bus.out_flag, bus.out_err, bus.out_op, s, f, e, op);
        end
        total++;
        if ({bus.ula_a, bus.ula_b, bus.ula_op} !== {pa, pb, pop}) begin
            bad++; $display("FAIL %s ula_hold: got %h/%h/%0d want %h/%h/%0d", tag,
                            bus.ula_a, bus.ula_b, bus.ula_op, pa, pb, pop);
        end
        hs = bus.out_s; hf = bus.out_flag; he = bus.out_err; ho = bus.out_op;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_op = 3'($urandom);
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.out_s, bus.out_flag, bus.out_err, bus.out_op} !== {hs, hf, he, ho}
                || {bus.ula_a, bus.ula_b, bus.ula_op} !== {pa, pb, pop}) begin
                bad++; $display("FAIL %s stall_hold: got v=%b r=%b s=%h op=%0d want v=1 r=0 s=%h op=%0d", tag,
                                bus.out_valid, bus.in_ready, bus.out_s, bus.out_op, hs, ho);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_count = (exp_count + 1) % 256;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL %s post_transfer: got v=%b r=%b want v=0 r=1", tag, bus.out_valid, bus.in_ready);
        end
        total++;
        if (bus.op_count !== 8'(exp_count)) begin
            bad++; $display("FAIL %s op_count: got %0d want %0d", tag, bus.op_count, exp_count);
        end
    endtask

    task automatic pulse_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset handshake: got r=%b v=%b want r=1 v=0", bus.in_ready, bus.out_valid);
        end
        total++;
        if ({bus.ula_a, bus.ula_b, bus.ula_op, bus.out_s, bus.out_flag, bus.out_err, bus.out_op, bus.op_count} !== '0) begin
            bad++; $display("FAIL reset data: got a=%h b=%h s=%h op=%0d cnt=%0d want all 0",
                            bus.ula_a, bus.ula_b, bus.out_s, bus.out_op, bus.op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_add();
        issue_and_check(8'h2A, 8'h15, 0, 0, "add");
        issue_and_check(8'hFF, 8'h01, 0, 1, "add_carry");
    endtask

    task automatic test_sub();
        issue_and_check(8'h10, 8'h20, 1, 0, "sub_borrow");
        issue_and_check(8'h80, 8'h01, 1, 0, "sub");
    endtask

    task automatic test_illegal();
        issue_and_check(8'h33, 8'h44, 5, 2, "illegal5");
        issue_and_check(8'h01, 8'h02, 2, 0, "illegal2");
    endtask

    task automatic test_backpressure();
        issue_and_check(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1, 10, "backpressure");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            issue_and_check(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), rand_op(),
                            int'($urandom_range(0, 3)), "random");
    endtask

    task automatic test_back_to_back();
        int qs[$], qf[$], qe[$], qo[$];
        int s, f, e, a, b, op, last, cyc, gap, xs, xf, xe, xo;
        bit prev_legal;
        last = -1; prev_legal = 1'b1; cyc = 0;
        bus.out_ready = 1'b1;
        while ((cyc < 60 || qs.size() != 0) && cyc < 120) begin
            if (bus.out_valid === 1'b1) begin
                total++;
                if (qs.size() == 0) begin
                    bad++; $display("FAIL b2b unexpected_result: got out_valid=1 want 0");
                end else begin
                    xs = qs.pop_front(); xf = qf.pop_front(); xe = qe.pop_front(); xo = qo.pop_front();
                    exp_count = (exp_count + 1) % 256;
                    if (bus.out_s !== 8'(xs) || bus.out_flag !== 1'(xf) || bus.out_err !== 1'(xe) || bus.out_op !== 3'(xo)) begin
                        bad++; $display("FAIL b2b result: got s=%h f=%b e=%b op=%0d want s=%h f=%0d e=%0d op=%0d",
                                        bus.out_s, bus.out_flag, bus.out_err, bus.out_op, xs, xf, xe, xo);
                    end
                end
            end
            if (bus.in_ready === 1'b1 && cyc < 60) begin
                a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255)); op = rand_op();
                bus.in_valid = 1'b1; bus.in_a = 8'(a); bus.in_b = 8'(b); bus.in_op = 3'(op);
                ref_model(a, b, op, s, f, e);
                qs.push_back(s); qf.push_back(f); qe.push_back(e); qo.push_back(op);
                if (last >= 0) begin
                    gap = prev_legal ? int'(LATENCY) + 3 : 2;
                    total++;
                    if (cyc - last != gap) begin
                        bad++; $display("FAIL b2b accept_gap: got %0d want %0d", cyc - last, gap);
                    end
                end
                last = cyc;
                prev_legal = (e == 0);
            end else begin
                bus.in_valid = (cyc < 60) ? 1'($urandom) : 1'b0;
                bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_op = 3'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        total++;
        if (qs.size() != 0) begin
            bad++; $display("FAIL b2b drain: got %0d pending want 0", qs.size());
        end
        total++;
        if (bus.op_count !== 8'(exp_count)) begin
            bad++; $display("FAIL b2b op_count: got %0d want %0d", bus.op_count, exp_count);
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        for (int i = 0; i < 256; i++)
            issue_and_check(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), rand_op(), 0, "wrap");
        total++;
        if (bus.op_count !== 8'd0) begin
            bad++; $display("FAIL wrap final_count: got %0d want 0", bus.op_count);
        end
    endtask

    task automatic test_reset_in_done();
        issue_and_check(8'h05, 8'h07, 0, 0, "pre_reset");
        bus.in_valid = 1'b1; bus.in_a = 8'h2A; bus.in_b = 8'h15; bus.in_op = 3'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            {bus.ula_a, bus.ula_b, bus.ula_op, bus.out_s, bus.out_flag, bus.out_err, bus.out_op, bus.op_count} !== '0) begin
            bad++; $display("FAIL reset_done async: got r=%b v=%b a=%h s=%h cnt=%0d want r=1 v=0 zeros",
                            bus.in_ready, bus.out_valid, bus.ula_a, bus.out_s, bus.op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_reset_mid_op();
        bus.in_valid = 1'b1; bus.in_a = 8'h2A; bus.in_b = 8'h15; bus.in_op = 3'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.op_count !== 8'd0 || bus.ula_a !== 8'd0) begin
            bad++; $display("FAIL reset_wait async: got r=%b v=%b cnt=%0d a=%h want r=1 v=0 cnt=0 a=0",
                            bus.in_ready, bus.out_valid, bus.op_count, bus.ula_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.op_count !== 8'd0) begin
                bad++; $display("FAIL reset_wait discard: got v=%b r=%b cnt=%0d want v=0 r=1 cnt=0",
                                bus.out_valid, bus.in_ready, bus.op_count);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_add();
        test_sub();
        test_illegal();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_in_done();
        test_wrap();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
